// File: rtl/mantissa_adder_unit.sv
// mantissa_adder_unit: multi-cycle sliced adder for 24-bit aligned mantissas
// Ports:
//   CLK, RSTn             clock (rising edge), synchronous active-low reset
//   Adder_valid           request; held until ack is seen, drop aborts compute
//   Adder_datain1/2       operands, captured only on the accept edge
//   Adder_dataout         24-bit sum, held until the next completion
//   Adder_carryout        carry out of bit 23
//   Adder_Exc             2'b01 on zero result (when enabled), else 2'b00
//   Adder_ack             result valid, held until valid drops
//   Debug                 registered state: IDLE=0, COMPUTE=1, DONE=2
module mantissa_adder_unit #(
    parameter int SLICE_W     = 8,
    parameter bit ZERO_EXC_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Adder_valid,
    input  logic [23:0] Adder_datain1,
    input  logic [23:0] Adder_datain2,
    output logic [23:0] Adder_dataout,
    output logic        Adder_carryout,
    output logic [1:0]  Adder_Exc,
    output logic        Adder_ack,
    output logic [1:0]  Debug
);
    localparam int N  = 24 / SLICE_W;
    localparam int IW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;
    logic [23:0] op_a, op_b, sum_q, sum_nxt;
    logic carry_q, last;
    logic [IW-1:0] idx;
    logic [SLICE_W:0] slice_sum;
    assign Debug = state;
    always_comb begin
        slice_sum = {1'b0, op_a[int'(idx)*SLICE_W +: SLICE_W]}
                  + {1'b0, op_b[int'(idx)*SLICE_W +: SLICE_W]}
                  + {{SLICE_W{1'b0}}, carry_q};
        sum_nxt = sum_q;
        sum_nxt[int'(idx)*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
        last = idx == IW'(N - 1);
        state_nxt = state == IDLE    ? (Adder_valid ? COMPUTE : IDLE) :
                    state == COMPUTE ? (!Adder_valid ? IDLE : last ? DONE : COMPUTE) :
                    state == DONE    ? (Adder_valid ? DONE : IDLE) : IDLE;
    end
    always_ff @(posedge CLK)
        state <= !RSTn ? IDLE : state_nxt;
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            op_a           <= '0;
            op_b           <= '0;
            sum_q          <= '0;
            carry_q        <= 1'b0;
            idx            <= '0;
            Adder_dataout  <= '0;
            Adder_carryout <= 1'b0;
            Adder_Exc      <= 2'b00;
            Adder_ack      <= 1'b0;
        end else begin
            if (state == IDLE && Adder_valid) begin
                op_a    <= Adder_datain1;
                op_b    <= Adder_datain2;
                idx     <= '0;
                carry_q <= 1'b0;
            end
            if (state == COMPUTE && Adder_valid) begin
                sum_q   <= sum_nxt;
                carry_q <= slice_sum[SLICE_W];
                idx     <= last ? '0 : idx + 1'b1;
                // the final slice is folded in here so the full sum lands in the same edge
                if (last) begin
                    Adder_dataout  <= sum_nxt;
                    Adder_carryout <= slice_sum[SLICE_W];
                    Adder_Exc      <= (ZERO_EXC_EN && sum_nxt == 24'd0 && !slice_sum[SLICE_W]) ? 2'b01 : 2'b00;
                    Adder_ack      <= 1'b1;
                end
            end
            if (state == DONE && !Adder_valid)
                Adder_ack <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mantissa_adder_unit.sv
// tb_mantissa_adder_unit: directed vectors with a queue-based result scoreboard
module tb_mantissa_adder_unit;
    logic CLK, RSTn, valid;
    logic [23:0] a, b, dout, dout_nz;
    logic carry, carry_nz, ack, ack_nz;
    logic [1:0] exc, exc_nz, dbg, dbg_nz;
    typedef struct packed {
        logic [23:0] d;
        logic        c;
        logic [1:0]  e;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int compared = 0, mismatched = 0;
    logic ack_prev = 1'b0;

    mantissa_adder_unit dut (
        .CLK(CLK), .RSTn(RSTn), .Adder_valid(valid),
        .Adder_datain1(a), .Adder_datain2(b),
        .Adder_dataout(dout), .Adder_carryout(carry), .Adder_Exc(exc),
        .Adder_ack(ack), .Debug(dbg)
    );
    mantissa_adder_unit #(.SLICE_W(8), .ZERO_EXC_EN(1'b0)) dut_nz (
        .CLK(CLK), .RSTn(RSTn), .Adder_valid(valid),
        .Adder_datain1(a), .Adder_datain2(b),
        .Adder_dataout(dout_nz), .Adder_carryout(carry_nz), .Adder_Exc(exc_nz),
        .Adder_ack(ack_nz), .Debug(dbg_nz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (ack && !ack_prev) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ack: got ack=1 want no ack (dataout %0h) at %0t", dout, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("dataout", 32'(dout), 32'(mon_e.d));
                chk("carryout", 32'(carry), 32'(mon_e.c));
                chk("exc", 32'(exc), 32'(mon_e.e));
                chk("nz_dataout", 32'(dout_nz), 32'(mon_e.d));
                chk("nz_exc", 32'(exc_nz), 32'd0);
                chk("nz_ack", 32'(ack_nz), 32'd1);
            end
        end
        ack_prev = ack;
    end

    task automatic request(input logic [23:0] x, input logic [23:0] y, input logic [23:0] d,
                           input logic c, input logic [1:0] e, input int hold);
        int n;
        a = x;
        b = y;
        valid = 1'b1;
        sb.push_back({d, c, e});
        @(negedge CLK);
        n = 1;
        chk("debug_compute", 32'(dbg), 32'd1);
        a = 24'($urandom);
        b = 24'($urandom);
        while (!ack && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("latency", n, 4);
        chk("debug_done", 32'(dbg), 32'd2);
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_dout", 32'(dout), 32'(d));
            chk("hold_carry", 32'(carry), 32'(c));
            chk("hold_ack", 32'(ack), 32'd1);
        end
        valid = 1'b0;
        @(negedge CLK);
        chk("ack_drop", 32'(ack), 32'd0);
        chk("debug_idle", 32'(dbg), 32'd0);
        chk("idle_dout", 32'(dout), 32'(d));
    endtask

    initial begin
        int n;
        RSTn = 1'b0;
        valid = 1'b1;
        a = 24'h555555;
        b = 24'h111111;
        repeat (2) @(negedge CLK);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_debug", 32'(dbg), 32'd0);
        valid = 1'b0;
        RSTn = 1'b1;
        @(negedge CLK);
        chk("idle_debug", 32'(dbg), 32'd0);

        request(24'h800000, 24'h800000, 24'h000000, 1'b1, 2'b00, 0);
        request(24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 2'b00, 1);
        request(24'h000000, 24'h000000, 24'h000000, 1'b0, 2'b01, 1);
        request(24'h00FF00, 24'h000100, 24'h010000, 1'b0, 2'b00, 0);
        request(24'h123456, 24'h0FEDCB, 24'h222221, 1'b0, 2'b00, 4);

        a = 24'h000010;
        b = 24'h000020;
        valid = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        valid = 1'b0;
        @(negedge CLK);
        chk("abort_debug", 32'(dbg), 32'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("abort_ack", 32'(ack), 32'd0);
            chk("abort_dout", 32'(dout), 32'h222221);
        end

        a = 24'hABCDEF;
        b = 24'h654321;
        valid = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_exc", 32'(exc), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_debug", 32'(dbg), 32'd0);
        @(negedge CLK);
        chk("inrst_debug", 32'(dbg), 32'd0);
        sb.push_back({24'h111110, 1'b1, 2'b00});
        RSTn = 1'b1;
        n = 0;
        while (!ack && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_release_latency", n, 4);
        valid = 1'b0;
        @(negedge CLK);
        chk("final_ack_drop", 32'(ack), 32'd0);
        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
